fullxor_sched: RTL and testbench
================================

Name: fullxor_sched

Overview:
- Round-robin scheduler sharing one masked full-XOR recombination unit (N_SHARES shares in, unmasked K_WIDTH word out, 1 registered stage) between N_REQ requesters.
- Pairs each issued operation with exactly one fresh randomness word-set from the RNG FIFO, so no randomness is ever reused.
- Returns each result tagged with the requester index, with output back-pressure, and supports a drain/flush sequence before key or context switches.

Parameters:
- K_WIDTH, 32, bits per share.
- N_SHARES, 4, shares per masked operand.
- RANDNUM, 4, random K_WIDTH words consumed per operation.
- N_REQ, 4, number of requesters.
- TAG_W, $clog2(N_REQ), width of the requester tag.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  N_REQ  per-requester operand valid.
- req_data  in  N_REQ*K_WIDTH*N_SHARES  masked operands; requester r at slice r.
- req_ready  out  N_REQ  one-hot grant / accept.
- rnd_valid  in  1  RNG FIFO has a word-set.
- rnd_data  in  K_WIDTH*RANDNUM  random words.
- rnd_ready  out  1  pop RNG FIFO.
- xu_x  out  K_WIDTH*N_SHARES  operand to unit.
- xu_rnd  out  K_WIDTH*RANDNUM  randomness to unit.
- xu_dvld  out  1  unit data valid.
- xu_ena  out  1  unit pipeline enable.
- xu_z  in  K_WIDTH  unit result.
- xu_ovld  in  1  unit output valid.
- out_valid  out  1  result valid.
- out_data  out  K_WIDTH  result.
- out_tag  out  TAG_W  requester index of the result.
- out_ready  in  1  consumer accept.
- flush  in  1  request drain (level).
- flush_done  out  1  pipeline empty, no grants while flush is high.
- err  out  1  sticky tag/valid mismatch.

Behaviour:
- Reset (async, rst_n=0): req_ready=0, rnd_ready=0, xu_dvld=0, xu_ena=0, out_valid=0, out_tag=0, flush_done=0, err=0, RR pointer=0, FSM=RUN, tag_q=0, tag_vld_q=0. xu_x and xu_rnd are driven 0.
- Enable: xu_ena = !(xu_ovld && !out_ready). The unit stage holds while the output is stalled. This is combinational from registered state plus out_ready.
- Issue condition: FSM==RUN && xu_ena && rnd_valid && |req_valid.
  - Winner is the first requester with req_valid set, searching from the RR pointer upward modulo N_REQ.
  - On issue: req_ready[winner]=1 and rnd_ready=1 in the same cycle; xu_dvld=1; xu_x=req_data[winner]; xu_rnd=rnd_data. The RR pointer becomes (winner+1) mod N_REQ.
  - With no issue, all ready outputs and xu_dvld are 0 and xu_x/xu_rnd are 0. Zeroing is mandatory so no share leaks.
  - No rnd_valid means no grant, even if requests are pending. Randomness is never popped without an operand, and an operand is never accepted without randomness.
- Tag pipeline: when xu_ena=1, tag_q<=winner and tag_vld_q<=issue. Otherwise both hold. This mirrors the unit's single stage, giving latency 1 from issue to out_valid when unstalled.
- Output: out_valid=xu_ovld, out_data=xu_z, out_tag=tag_q. Transfer occurs on out_valid&&out_ready. Throughput is 1 op/cycle when out_ready stays high.
- Check: if xu_ovld != tag_vld_q in any cycle, err<=1 and stays set until reset.
- FSM:
  - RUN: issues per the rules above. flush=1 -> DRAIN; the issue is blocked in that same cycle.
  - DRAIN: no issue. When tag_vld_q==0 (unit empty, last result transferred) -> DONE.
  - DONE: flush_done=1 (registered, asserted from the first DONE cycle). flush=0 -> RUN; flush_done=0 the next cycle.
- Boundaries:
  - Simultaneous flush and issue-eligible request: flush wins, no grant.
  - Output stalled with a new request pending: no grant, because xu_ena=0.
  - Single requester: granted every eligible cycle.
  - RR pointer wraps N_REQ-1 -> 0.
  - Reset mid-operation drops any in-flight result. out_valid falls immediately with rst_n.

Decomposition:
- Package fullxor_pkg: K_WIDTH/N_SHARES defaults, the RANDNUM function (LOG_K*2^(LOG_K-1)+N_SHARES-2^LOG_K with LOG_K=clog2(N_SHARES+1)-1, 0 when N_SHARES==1), and the FSM state encoding (RUN=2'd0, DRAIN=2'd1, DONE=2'd2).
- One sub-module, rr_arbiter: N_REQ-wide round-robin grant with pointer register and advance enable. The operand mux, tag pipeline, FSM and error check stay in fullxor_sched.

Test Plan:
- Single op: req_valid=4'b0010, shares {A,B,C,D}, rnd_valid=1, out_ready=1 -> req_ready=4'b0010 and rnd_ready=1 in cycle 0; out_valid=1, out_tag=1, out_data=A^B^C^D in cycle 1 (with the unit model).
- Fairness: all 4 requesters hold valid for 8 cycles with rnd always valid -> grant order 0,1,2,3,0,1,2,3; 8 results, tags in that order.
- RNG starvation: rnd_valid=0 for 5 cycles with req_valid=4'b1111 -> no req_ready, xu_dvld=0, xu_x=0; first grant in the cycle rnd_valid rises.
- Back-pressure: out_ready=0 for 3 cycles with a result pending -> out_data/out_tag stable, xu_ena=0, no grants, no rnd pops; all resume when out_ready=1.
- Flush: flush=1 while an op is in flight -> no further grants, result delivered, flush_done=1 one cycle after the pipeline empties; flush=0 -> grants resume from the saved RR pointer.
- Reset mid-stream: rst_n=0 during an in-flight op -> all outputs 0 immediately; after release the first grant goes to requester 0; err=0.

Source files
------------

// File: rtl/fullxor_pkg.sv
// Shared defaults, FSM encoding and the randomness-count helper for the
// scheduled masked full-XOR recombination unit.
package fullxor_pkg;

  localparam int K_WIDTH_DEF  = 32;
  localparam int N_SHARES_DEF = 4;

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_DRAIN = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // Random words the unit consumes per operation for a given share count.
  function automatic int randnum(input int n_shares);
    int log_k;
    log_k = $clog2(n_shares + 1) - 1;
    if (n_shares == 1) begin
      randnum = 0;
    end else begin
      randnum = log_k * (1 << (log_k - 1)) + n_shares - (1 << log_k);
    end
  endfunction

endpackage

// File: rtl/fullxor_sched_rr_arbiter.sv
// Round-robin arbiter: searches upward from the pointer, and the pointer
// moves past the winner only when the grant is actually used.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int TAG_W = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic             adv,
  output logic [N_REQ-1:0] grant,
  output logic [TAG_W-1:0] winner,
  output logic             any
);

  logic [TAG_W-1:0] ptr;
  int               idx;

  // First requester at or after ptr, wrapping modulo N_REQ.
  always_comb begin
    grant  = '0;
    winner = '0;
    any    = 1'b0;
    idx    = 0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = (int'(ptr) + i) % N_REQ;
      if (!any && req[idx]) begin
        any        = 1'b1;
        winner     = TAG_W'(idx);
        grant[idx] = 1'b1;
      end else begin
        any = any;
      end
    end
  end

  // Pointer register: next search starts just past the last used winner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (adv) begin
      ptr <= (winner == TAG_W'(N_REQ - 1)) ? '0 : winner + TAG_W'(1);
    end else begin
      ptr <= ptr;
    end
  end

endmodule

// File: rtl/fullxor_sched.sv
// Shares one single-stage masked full-XOR unit between N_REQ requesters,
// pairing every issued operand with exactly one fresh randomness word-set.
module fullxor_sched
  import fullxor_pkg::*;
#(
  parameter int K_WIDTH  = K_WIDTH_DEF,
  parameter int N_SHARES = N_SHARES_DEF,
  parameter int RANDNUM  = randnum(N_SHARES),
  parameter int N_REQ    = 4,
  parameter int TAG_W    = $clog2(N_REQ)
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [N_REQ-1:0]                   req_valid,
  input  logic [N_REQ*K_WIDTH*N_SHARES-1:0]  req_data,
  output logic [N_REQ-1:0]                   req_ready,
  input  logic                               rnd_valid,
  input  logic [K_WIDTH*RANDNUM-1:0]         rnd_data,
  output logic                               rnd_ready,
  output logic [K_WIDTH*N_SHARES-1:0]        xu_x,
  output logic [K_WIDTH*RANDNUM-1:0]         xu_rnd,
  output logic                               xu_dvld,
  output logic                               xu_ena,
  input  logic [K_WIDTH-1:0]                 xu_z,
  input  logic                               xu_ovld,
  output logic                               out_valid,
  output logic [K_WIDTH-1:0]                 out_data,
  output logic [TAG_W-1:0]                   out_tag,
  input  logic                               out_ready,
  input  logic                               flush,
  output logic                               flush_done,
  output logic                               err
);

  localparam int OP_W = K_WIDTH * N_SHARES;

  state_t           state, state_next;
  logic             ena, issue, any_req;
  logic [N_REQ-1:0] grant;
  logic [TAG_W-1:0] winner;
  logic [TAG_W-1:0] tag_q;
  logic             tag_vld_q;

  // The unit stage (and our tag stage) freezes while a result is stalled.
  assign ena       = rst_n & ~(xu_ovld & ~out_ready);
  assign xu_ena    = ena;
  assign out_valid = xu_ovld & rst_n;
  assign out_data  = xu_z;
  assign out_tag   = tag_q;

  rr_arbiter #(.N_REQ(N_REQ), .TAG_W(TAG_W)) u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req_valid),
    .adv    (issue),
    .grant  (grant),
    .winner (winner),
    .any    (any_req)
  );

  // Next state and issue decision; flush takes priority over a grant.
  always_comb begin
    state_next = state;
    issue      = 1'b0;
    case (state)
      S_RUN: begin
        if (flush) begin
          state_next = S_DRAIN;
        end else begin
          state_next = S_RUN;
          issue      = ena & rnd_valid & any_req;
        end
      end
      S_DRAIN: begin
        if (!tag_vld_q) state_next = S_DONE;
        else            state_next = S_DRAIN;
      end
      S_DONE: begin
        if (!flush) state_next = S_RUN;
        else        state_next = S_DONE;
      end
      default: state_next = S_RUN;
    endcase
  end

  // Unit-facing data is zeroed whenever nothing issues so no share leaks.
  always_comb begin
    req_ready = '0;
    rnd_ready = 1'b0;
    xu_dvld   = 1'b0;
    xu_x      = '0;
    xu_rnd    = '0;
    if (issue) begin
      req_ready = grant;
      rnd_ready = 1'b1;
      xu_dvld   = 1'b1;
      xu_x      = req_data[int'(winner)*OP_W +: OP_W];
      xu_rnd    = rnd_data;
    end else begin
      xu_x   = '0;
      xu_rnd = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_RUN;
      flush_done <= 1'b0;
    end else begin
      state      <= state_next;
      flush_done <= (state_next == S_DONE);
    end
  end

  // Tag stage mirrors the unit's single pipeline register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_q     <= '0;
      tag_vld_q <= 1'b0;
    end else if (ena) begin
      tag_q     <= winner;
      tag_vld_q <= issue;
    end else begin
      tag_q     <= tag_q;
      tag_vld_q <= tag_vld_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (xu_ovld != tag_vld_q) begin
      err <= 1'b1;
    end else begin
      err <= err;
    end
  end

endmodule

// File: tb/tb_fullxor_sched.sv
// Directed bench for fullxor_sched with a one-stage XOR unit model.
module tb_fullxor_sched;

  localparam int KW  = 32;
  localparam int NR  = 4;
  localparam int OPW = KW * 4;

  logic              clk;
  logic              rst_n;
  logic [NR-1:0]     req_valid;
  logic [NR*OPW-1:0] req_data;
  logic [NR-1:0]     req_ready;
  logic              rnd_valid;
  logic [KW*4-1:0]   rnd_data;
  logic              rnd_ready;
  logic [OPW-1:0]    xu_x;
  logic [KW*4-1:0]   xu_rnd;
  logic              xu_dvld;
  logic              xu_ena;
  logic [KW-1:0]     xu_z;
  logic              xu_ovld;
  logic              out_valid;
  logic [KW-1:0]     out_data;
  logic [1:0]        out_tag;
  logic              out_ready;
  logic              flush;
  logic              flush_done;
  logic              err;

  logic              mdl_ovld;
  logic [KW-1:0]     mdl_z;
  logic              inj;

  int n_vec = 0;
  int n_err = 0;

  fullxor_sched dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .rnd_valid(rnd_valid), .rnd_data(rnd_data), .rnd_ready(rnd_ready),
    .xu_x(xu_x), .xu_rnd(xu_rnd), .xu_dvld(xu_dvld), .xu_ena(xu_ena),
    .xu_z(xu_z), .xu_ovld(xu_ovld),
    .out_valid(out_valid), .out_data(out_data), .out_tag(out_tag),
    .out_ready(out_ready), .flush(flush), .flush_done(flush_done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Recombination unit model: one enabled register stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mdl_ovld <= 1'b0;
      mdl_z    <= '0;
    end else if (xu_ena) begin
      mdl_ovld <= xu_dvld;
      mdl_z    <= xu_x[31:0] ^ xu_x[63:32] ^ xu_x[95:64] ^ xu_x[127:96];
    end
  end
  assign xu_ovld = mdl_ovld ^ inj;
  assign xu_z    = mdl_z;

  function automatic logic [31:0] zexp(input int r);
    logic [OPW-1:0] op;
    op = req_data[r*OPW +: OPW];
    return op[31:0] ^ op[63:32] ^ op[95:64] ^ op[127:96];
  endfunction

  function automatic int oh2idx(input logic [3:0] g);
    int k;
    k = 0;
    for (int i = 0; i < 4; i++) if (g[i]) k = i;
    return k;
  endfunction

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One cycle: drive at negedge, check combinational and registered outputs.
  task automatic cyc(input logic [3:0] rv, input logic rndv, input logic ordy, input logic fl,
                     input logic [3:0] eg, input logic eov, input int etag, input logic efd);
    @(negedge clk);
    req_valid = rv; rnd_valid = rndv; out_ready = ordy; flush = fl;
    #1;
    check("req_ready", req_ready, eg);
    check("rnd_ready", rnd_ready, eg != 4'd0);
    check("xu_dvld", xu_dvld, eg != 4'd0);
    check("xu_x", xu_x, (eg != 4'd0) ? req_data[oh2idx(eg)*OPW +: OPW] : 128'd0);
    check("xu_rnd", xu_rnd, (eg != 4'd0) ? rnd_data : 128'd0);
    check("xu_ena", xu_ena, !(eov && !ordy));
    check("out_valid", out_valid, eov);
    if (eov) begin
      check("out_tag", out_tag, etag[1:0]);
      check("out_data", out_data, zexp(etag));
    end
    check("flush_done", flush_done, efd);
    check("err", err, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; inj = 1'b0;
    req_valid = 4'b1111; rnd_valid = 1'b1; out_ready = 1'b1; flush = 1'b0;
    rnd_data = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_CAFE_F00D;
    for (int r = 0; r < NR; r++)
      for (int s = 0; s < 4; s++)
        req_data[r*OPW + s*KW +: KW] = 32'h0101_0101 * (r*4 + s + 1);
    req_data[1*OPW +: OPW] = {32'h8888_1000, 32'h4444_0100, 32'h2222_0010, 32'h1111_0001};

    #2;
    check("rst_req_ready", req_ready, 4'd0);
    check("rst_rnd_ready", rnd_ready, 1'b0);
    check("rst_xu_dvld", xu_dvld, 1'b0);
    check("rst_xu_ena", xu_ena, 1'b0);
    check("rst_xu_x", xu_x, 128'd0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_tag", out_tag, 2'd0);
    check("rst_flush_done", flush_done, 1'b0);
    check("rst_err", err, 1'b0);
    @(negedge clk);
    req_valid = 4'b0000;
    rst_n = 1'b1;

    // Single op from requester 1
    cyc(4'b0010, 1'b1, 1'b1, 1'b0, 4'b0010, 1'b0, 0, 1'b0);
    cyc(4'b0000, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b1, 1, 1'b0);
    check("single_data", out_data, 32'hFFFF_1111);

    // Lone requester 3, granted back to back; pointer wraps to 0
    cyc(4'b1000, 1'b1, 1'b1, 1'b0, 4'b1000, 1'b0, 0, 1'b0);
    cyc(4'b1000, 1'b1, 1'b1, 1'b0, 4'b1000, 1'b1, 3, 1'b0);
    cyc(4'b0000, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b1, 3, 1'b0);

    // Fairness: all requesting, order 0,1,2,3,0,1,2,3
    for (int i = 0; i < 8; i++)
      cyc(4'b1111, 1'b1, 1'b1, 1'b0, 4'(1 << (i % 4)), i > 0, (i + 3) % 4, 1'b0);
    cyc(4'b0000, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b1, 3, 1'b0);

    // RNG starvation
    for (int i = 0; i < 5; i++)
      cyc(4'b1111, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 0, 1'b0);
    cyc(4'b1111, 1'b1, 1'b1, 1'b0, 4'b0001, 1'b0, 0, 1'b0);
    cyc(4'b0000, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b1, 0, 1'b0);

    // Back-pressure: result for tag 1 held three cycles
    cyc(4'b1111, 1'b1, 1'b0, 1'b0, 4'b0010, 1'b0, 0, 1'b0);
    for (int i = 0; i < 3; i++)
      cyc(4'b1111, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b1, 1, 1'b0);
    cyc(4'b1111, 1'b1, 1'b1, 1'b0, 4'b0100, 1'b1, 1, 1'b0);
    cyc(4'b0000, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b1, 2, 1'b0);

    // Flush with one op in flight
    cyc(4'b1111, 1'b1, 1'b1, 1'b0, 4'b1000, 1'b0, 0, 1'b0);
    cyc(4'b1111, 1'b1, 1'b1, 1'b1, 4'b0000, 1'b1, 3, 1'b0);
    cyc(4'b1111, 1'b1, 1'b1, 1'b1, 4'b0000, 1'b0, 0, 1'b0);
    cyc(4'b1111, 1'b1, 1'b1, 1'b1, 4'b0000, 1'b0, 0, 1'b1);
    cyc(4'b1111, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 0, 1'b1);
    cyc(4'b1111, 1'b1, 1'b1, 1'b0, 4'b0001, 1'b0, 0, 1'b0);
    cyc(4'b0000, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b1, 0, 1'b0);

    // Reset with the op for requester 2 in flight
    cyc(4'b0100, 1'b1, 1'b1, 1'b0, 4'b0100, 1'b0, 0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0; req_valid = 4'b1111;
    #1;
    check("mid_rst_out_valid", out_valid, 1'b0);
    check("mid_rst_out_tag", out_tag, 2'd0);
    check("mid_rst_req_ready", req_ready, 4'd0);
    check("mid_rst_rnd_ready", rnd_ready, 1'b0);
    check("mid_rst_xu_ena", xu_ena, 1'b0);
    check("mid_rst_xu_x", xu_x, 128'd0);
    check("mid_rst_err", err, 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    cyc(4'b1111, 1'b1, 1'b1, 1'b0, 4'b0001, 1'b0, 0, 1'b0);
    cyc(4'b0000, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b1, 0, 1'b0);

    // Spurious unit valid must set the sticky error
    @(negedge clk);
    req_valid = 4'b0000; rnd_valid = 1'b0; inj = 1'b1;
    @(negedge clk);
    inj = 1'b0;
    #1 check("err_set", err, 1'b1);
    @(negedge clk);
    #1 check("err_sticky", err, 1'b1);
    rst_n = 1'b0;
    #1 check("err_cleared", err, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
